// File: rtl/imem_dmem_arbiter.sv
// Purpose : shares one single-port memory between instruction fetch and data
//           access. Data has priority; a streak counter bounds fetch latency,
//           and a timeout aborts a hung memory transaction.
// Latency : request to mem_req is 1 cycle; mem_ack to done is 1 cycle. The
//           minimum from request to done is 2 cycles.
// Backpressure: a requester holds req until its done pulse, and sees stall
//           until then. mem_req is held until mem_ack arrives or the
//           transaction is aborted.
// Ports:
//   clk, reset                        - clock, synchronous active-high reset
//   if_req/if_addr -> if_rdata/if_done/if_err/if_stall   fetch port
//   d_req/d_we/d_addr/d_wdata -> d_rdata/d_done/d_err/d_stall  data port
//   mem_req/mem_we/mem_addr/mem_wdata <- mem_ack/mem_rdata  memory side
module imem_dmem_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic          clk,
  input  logic          reset,
  // fetch port
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  output logic          if_err,
  output logic          if_stall,
  // data port
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_done,
  output logic          d_err,
  output logic          d_stall,
  // memory side
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
  localparam logic [TW-1:0] TMO_LIMIT  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          if_done_q, if_done_d;
  logic          d_done_q, d_done_d;
  logic          if_err_q, if_err_d;
  logic          d_err_q, d_err_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [TW-1:0] tmo_q, tmo_d;

  // A request seen in its own done cycle is the one just completed.
  logic if_elig, d_elig, grant_d, grant_i;
  assign if_elig = if_req & ~if_done_q;
  assign d_elig  = d_req & ~d_done_q;
  assign grant_d = d_elig & (~if_elig | (streak_q < STREAK_MAX));
  assign grant_i = if_elig & ~grant_d;

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_done_d   = 1'b0;
    d_done_d    = 1'b0;
    if_err_d    = 1'b0;
    d_err_d     = 1'b0;
    streak_d    = streak_q;
    tmo_d       = tmo_q;

    unique case (state_q)
      IDLE: begin
        mem_req_d = 1'b0;
        if (grant_d) begin
          state_d     = BUSY_D;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          tmo_d       = '0;
          // Only consecutive data grants that keep a fetch waiting count.
          if (!if_req)                     streak_d = '0;
          else if (streak_q != STREAK_MAX) streak_d = streak_q + SW'(1);
        end else if (grant_i) begin
          state_d     = BUSY_I;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          tmo_d       = '0;
          streak_d    = '0;
        end
      end

      BUSY_I, BUSY_D: begin
        if (mem_ack) begin
          // Ack wins over a timeout hitting in the same cycle.
          state_d   = IDLE;
          mem_req_d = 1'b0;
          if (state_q == BUSY_D) begin
            d_rdata_d = mem_rdata;
            d_done_d  = 1'b1;
          end else begin
            if_rdata_d = mem_rdata;
            if_done_d  = 1'b1;
          end
        end else if (tmo_q == TMO_LIMIT) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          if (state_q == BUSY_D) begin
            d_rdata_d = '0;
            d_done_d  = 1'b1;
            d_err_d   = 1'b1;
          end else begin
            if_rdata_d = '0;
            if_done_d  = 1'b1;
            if_err_d   = 1'b1;
          end
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      if_err_q    <= 1'b0;
      d_err_q     <= 1'b0;
      streak_q    <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_done_q   <= if_done_d;
      d_done_q    <= d_done_d;
      if_err_q    <= if_err_d;
      d_err_q     <= d_err_d;
      streak_q    <= streak_d;
      tmo_q       <= tmo_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_done   = if_done_q;
  assign d_done    = d_done_q;
  assign if_err    = if_err_q;
  assign d_err     = d_err_q;
  assign if_stall  = if_req & ~if_done_q;
  assign d_stall   = d_req & ~d_done_q;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench for imem_dmem_arbiter with MAX_D_STREAK=4, TIMEOUT=8.
// A memory responder inside tick() acks on a chosen mem_req cycle and
// returns 0x00500093 for address 0x100, else the inverted address.
module tb_imem_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_done, if_err, if_stall;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_done, d_err, d_stall;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  imem_dmem_arbiter #(
    .AW(32), .DW(32), .MAX_D_STREAK(4), .TIMEOUT(8)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_done(if_done), .if_err(if_err), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .d_err(d_err), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          ack_dly = 0;
  int          req_cyc = 0;
  int          req_hi_cnt = 0;
  logic        prev_req = 1'b0;
  logic [31:0] grant_log[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge, run the memory responder, log grants.
  task automatic tick();
    @(negedge clk);
    if (mem_req) begin
      if (req_cyc == ack_dly) begin
        mem_ack   = 1'b1;
        mem_rdata = (mem_addr == 32'h100) ? 32'h0050_0093 : ~mem_addr;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 32'hBAD0_BAD0;
      end
      req_cyc++;
      req_hi_cnt++;
      if (!prev_req) grant_log.push_back(mem_addr);
    end else begin
      mem_ack = 1'b0;
      req_cyc = 0;
    end
    prev_req = mem_req;
  endtask

  task automatic wait_done(input bit is_d, input int bound, output int cyc);
    cyc = 0;
    for (int i = 0; i < bound; i++) begin
      tick();
      cyc++;
      if (is_d ? d_done : if_done) return;
    end
    if (is_d) check_eq("d_done_wait_expired", 32'd0, 32'd1);
    else      check_eq("if_done_wait_expired", 32'd0, 32'd1);
  endtask

  int cyc;
  int done_seen;

  initial begin
    reset = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    tick(); tick();

    // reset state
    check_eq("rst_mem_req", 32'(mem_req), 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'd0);
    check_eq("rst_if_done", 32'(if_done), 32'd0);
    check_eq("rst_d_done", 32'(d_done), 32'd0);
    check_eq("rst_if_rdata", if_rdata, 32'd0);
    check_eq("rst_d_rdata", d_rdata, 32'd0);
    reset = 1'b0;
    tick();

    // single fetch, ack on the 4th mem_req cycle
    ack_dly = 3;
    if_addr = 32'h100; if_req = 1'b1;
    tick();
    check_eq("f1_stall", 32'(if_stall), 32'd1);
    check_eq("f1_mem_req", 32'(mem_req), 32'd1);
    check_eq("f1_mem_addr", mem_addr, 32'h100);
    check_eq("f1_mem_we", 32'(mem_we), 32'd0);
    wait_done(1'b0, 20, cyc);
    check_eq("f1_latency", 32'(cyc + 1), 32'd5);
    check_eq("f1_rdata", if_rdata, 32'h0050_0093);
    check_eq("f1_err", 32'(if_err), 32'd0);
    check_eq("f1_stall_done", 32'(if_stall), 32'd0);
    if_req = 1'b0;
    tick();

    // collision: store wins, fetch granted in the d_done cycle
    ack_dly = 0;
    if_addr = 32'h200; if_req = 1'b1;
    d_addr = 32'h2000; d_we = 1'b1; d_wdata = 32'hDEAD_BEEF; d_req = 1'b1;
    tick();
    check_eq("col_mem_addr", mem_addr, 32'h2000);
    check_eq("col_mem_we", 32'(mem_we), 32'd1);
    check_eq("col_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    tick();
    check_eq("col_d_done", 32'(d_done), 32'd1);
    check_eq("col_d_rdata", d_rdata, 32'hFFFF_DFFF);
    check_eq("col_d_stall", 32'(d_stall), 32'd0);
    check_eq("col_if_stall", 32'(if_stall), 32'd1);
    check_eq("col_if_done", 32'(if_done), 32'd0);
    d_req = 1'b0; d_we = 1'b0;
    tick();
    check_eq("col_f_mem_req", 32'(mem_req), 32'd1);
    check_eq("col_f_mem_addr", mem_addr, 32'h200);
    check_eq("col_f_mem_we", 32'(mem_we), 32'd0);
    check_eq("col_f_mem_wdata", mem_wdata, 32'd0);
    tick();
    check_eq("col_f_done", 32'(if_done), 32'd1);
    check_eq("col_f_rdata", if_rdata, 32'hFFFF_FDFF);
    if_req = 1'b0;
    tick();

    // streak cap: the fetch requester withdraws in each d_done cycle so both
    // ports meet again in IDLE; expect 4 data grants, 1 fetch, then data.
    ack_dly = 1;
    grant_log.delete();
    if_addr = 32'h400; d_addr = 32'h3000; d_we = 1'b0;
    if_req = 1'b1; d_req = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (grant_log.size() >= 6) break;
      if_req = ~d_done;
    end
    if_req = 1'b0; d_req = 1'b0;
    check_eq("stk_count", 32'(grant_log.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < grant_log.size())
        check_eq($sformatf("stk_grant%0d", i), grant_log[i], (i == 4) ? 32'h400 : 32'h3000);
    end
    repeat (6) tick();
    check_eq("stk_if_rdata", if_rdata, 32'hFFFF_FBFF);

    // timeout: load never acked
    ack_dly = 100;
    req_hi_cnt = 0;
    d_addr = 32'h5000; d_we = 1'b0; d_req = 1'b1;
    wait_done(1'b1, 30, cyc);
    check_eq("tmo_latency", 32'(cyc), 32'd9);
    check_eq("tmo_req_cycles", 32'(req_hi_cnt), 32'd8);
    check_eq("tmo_err", 32'(d_err), 32'd1);
    check_eq("tmo_rdata", d_rdata, 32'd0);
    check_eq("tmo_mem_req", 32'(mem_req), 32'd0);
    d_req = 1'b0;
    tick();
    check_eq("tmo_err_pulse", 32'(d_err), 32'd0);

    // ack exactly at the limit cycle wins
    ack_dly = 7;
    req_hi_cnt = 0;
    d_addr = 32'h5004; d_req = 1'b1;
    wait_done(1'b1, 30, cyc);
    check_eq("lim_req_cycles", 32'(req_hi_cnt), 32'd8);
    check_eq("lim_err", 32'(d_err), 32'd0);
    check_eq("lim_rdata", d_rdata, 32'hFFFF_AFFB);
    d_req = 1'b0;
    tick();

    // reset during an outstanding fetch
    ack_dly = 100;
    if_addr = 32'h600; if_req = 1'b1;
    tick(); tick(); tick();
    check_eq("rmid_busy", 32'(mem_req), 32'd1);
    reset = 1'b1; if_req = 1'b0;
    tick();
    check_eq("rmid_mem_req", 32'(mem_req), 32'd0);
    check_eq("rmid_if_rdata", if_rdata, 32'd0);
    reset = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (if_done || mem_req) done_seen++;
    end
    check_eq("rmid_no_done", 32'(done_seen), 32'd0);
    ack_dly = 0;
    if_addr = 32'h100; if_req = 1'b1;
    wait_done(1'b0, 10, cyc);
    check_eq("rmid_new_latency", 32'(cyc), 32'd2);
    check_eq("rmid_new_rdata", if_rdata, 32'h0050_0093);
    check_eq("rmid_new_err", 32'(if_err), 32'd0);
    if_req = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog");
  end

endmodule
